// File: rtl/des_load_sequencer_if.sv
// Bundle between the hex entry stage / DES core and the load sequencer.
// The sequencer takes the slave modport; whoever drives the entry and core side takes master.
interface des_load_sequencer_if;
    logic [63:0] values;
    logic [4:0]  nEntered;
    logic        go_n;
    logic        decrypt_sw;
    logic        core_done;
    logic [63:0] core_result;
    logic        entry_clr_n;
    logic [63:0] key_reg;
    logic [63:0] data_reg;
    logic        core_start;
    logic        core_decrypt;
    logic [63:0] result;
    logic        result_valid;
    logic        err;
    logic [2:0]  state;

    modport master (
        output values, nEntered, go_n, decrypt_sw, core_done, core_result,
        input  entry_clr_n, key_reg, data_reg, core_start, core_decrypt,
               result, result_valid, err, state
    );

    modport slave (
        input  values, nEntered, go_n, decrypt_sw, core_done, core_result,
        output entry_clr_n, key_reg, data_reg, core_start, core_decrypt,
               result, result_valid, err, state
    );
endinterface

// File: rtl/des_load_sequencer.sv
// Captures a key and then data blocks from the hex entry stage, runs the DES core
// with a start/done handshake and a timeout, and latches the core's result for display.
module des_load_sequencer #(
    parameter int DIGITS     = 16,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    des_load_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_KEY   = 3'd0,
        S_DATA  = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [4:0]  FULL_COUNT = 5'(DIGITS);
    localparam logic [3:0]  CLR_LOAD   = 4'(CLR_CYCLES);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_go_prev;
    logic [3:0]  r_clr_cnt;
    logic        r_entry_clr_n;
    logic [15:0] r_tmo_cnt;
    logic [63:0] r_key;
    logic [63:0] r_data;
    logic [63:0] r_result;
    logic        r_result_valid;
    logic        r_core_start;
    logic        r_core_decrypt;
    logic        r_err;

    logic w_press;
    logic w_full;
    logic w_clr_active;

    assign w_press      = r_go_prev & ~bus.go_n;
    assign w_full       = (bus.nEntered == FULL_COUNT);
    assign w_clr_active = (r_clr_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_KEY;
            r_go_prev      <= 1'b1;
            r_clr_cnt      <= 4'd0;
            r_entry_clr_n  <= 1'b1;
            r_tmo_cnt      <= 16'd0;
            r_key          <= 64'd0;
            r_data         <= 64'd0;
            r_result       <= 64'd0;
            r_result_valid <= 1'b0;
            r_core_start   <= 1'b0;
            r_core_decrypt <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_go_prev    <= bus.go_n;
            r_core_start <= 1'b0;

            // Clear pulse runs down here; a capture below reloads it and wins.
            if (w_clr_active) begin
                r_clr_cnt     <= r_clr_cnt - 4'd1;
                r_entry_clr_n <= (r_clr_cnt == 4'd1);
            end else begin
                r_entry_clr_n <= 1'b1;
            end

            case (r_state)
                S_KEY: begin
                    if (w_press && w_full) begin
                        r_key         <= bus.values;
                        r_clr_cnt     <= CLR_LOAD;
                        r_entry_clr_n <= 1'b0;
                        r_state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_press && w_full && !w_clr_active) begin
                        r_data        <= bus.values;
                        r_clr_cnt     <= CLR_LOAD;
                        r_entry_clr_n <= 1'b0;
                        r_core_start  <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    r_core_decrypt <= bus.decrypt_sw;
                    r_tmo_cnt      <= 16'd0;
                    r_state        <= S_BUSY;
                end
                S_BUSY: begin
                    // Done takes priority over the terminal count in the same cycle.
                    if (bus.core_done) begin
                        r_result       <= bus.core_result;
                        r_result_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    if (w_press) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_DATA;
                    end
                end
                S_ERROR: begin
                    if (w_press) begin
                        r_err         <= 1'b0;
                        r_key         <= 64'd0;
                        r_data        <= 64'd0;
                        r_result      <= 64'd0;
                        r_clr_cnt     <= CLR_LOAD;
                        r_entry_clr_n <= 1'b0;
                        r_state       <= S_KEY;
                    end
                end
                default: r_state <= S_KEY;
            endcase
        end
    end

    assign bus.entry_clr_n  = r_entry_clr_n;
    assign bus.key_reg      = r_key;
    assign bus.data_reg     = r_data;
    assign bus.core_start   = r_core_start;
    assign bus.core_decrypt = r_core_decrypt;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.err          = r_err;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_des_load_sequencer.sv
// Directed bench for des_load_sequencer: dutA uses the default timeout, dutB a short
// timeout of 8; both see the same stimulus, and each step checks whichever instance it targets.
module tb_des_load_sequencer;
    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] DATA1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] RES1 = 64'h85E813540F0AB405;
    localparam logic [63:0] RES2 = 64'h1122334455667788;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] values;
    logic [4:0]  nEntered;
    logic        goN;
    logic        decryptSw;
    logic        coreDone;
    logic [63:0] coreResult;
    int          checks = 0;
    int          errors = 0;
    int          startCount;

    des_load_sequencer_if ifA ();
    des_load_sequencer_if ifB ();

    assign ifA.values = values;
    assign ifA.nEntered = nEntered;
    assign ifA.go_n = goN;
    assign ifA.decrypt_sw = decryptSw;
    assign ifA.core_done = coreDone;
    assign ifA.core_result = coreResult;
    assign ifB.values = values;
    assign ifB.nEntered = nEntered;
    assign ifB.go_n = goN;
    assign ifB.decrypt_sw = decryptSw;
    assign ifB.core_done = coreDone;
    assign ifB.core_result = coreResult;

    des_load_sequencer dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
    des_load_sequencer #(.TIMEOUT(8)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] v, input logic [4:0] n);
        values = v;
        nEntered = n;
    endtask

    // Button released for a full cycle, then pressed across exactly one rising edge.
    task automatic pressGo();
        goN = 1'b1;
        step(1);
        goN = 1'b0;
        step(1);
        goN = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        values = '0;
        nEntered = '0;
        goN = 1'b1;
        decryptSw = 1'b0;
        coreDone = 1'b0;
        coreResult = '0;
        step(2);
        checkOutput("rst_state", ifA.state, 0);
        checkOutput("rst_clr_n", ifA.entry_clr_n, 1);
        checkOutput("rst_start", ifA.core_start, 0);
        checkOutput("rst_valid", ifA.result_valid, 0);
        rst = 1'b0;

        // Key capture, clear pulse width, then reset while busy.
        applyStimulus(KEY1, 16);
        pressGo();
        checkOutput("t1_key", ifA.key_reg, KEY1);
        checkOutput("t1_state", ifA.state, 1);
        checkOutput("t1_clr0", ifA.entry_clr_n, 0);
        step(1);
        checkOutput("t1_clr1", ifA.entry_clr_n, 0);
        step(1);
        checkOutput("t1_clr2", ifA.entry_clr_n, 1);
        applyStimulus(DATA1, 16);
        pressGo();
        checkOutput("t1_start", ifA.state, 2);
        step(1);
        checkOutput("t1_busy", ifA.state, 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("t1_rst_state", ifA.state, 0);
        checkOutput("t1_rst_key", ifA.key_reg, 0);
        checkOutput("t1_rst_data", ifA.data_reg, 0);
        checkOutput("t1_rst_clr_n", ifA.entry_clr_n, 1);
        coreDone = 1'b1;
        coreResult = RES1;
        step(1);
        coreDone = 1'b0;
        checkOutput("t1_late_result", ifA.result, 0);
        checkOutput("t1_late_valid", ifA.result_valid, 0);
        checkOutput("t1_late_state", ifA.state, 0);

        // Full encrypt flow.
        applyStimulus(KEY1, 16);
        pressGo();
        step(2);
        applyStimulus(DATA1, 16);
        decryptSw = 1'b0;
        pressGo();
        checkOutput("t2_core_start", ifA.core_start, 1);
        checkOutput("t2_data", ifA.data_reg, DATA1);
        step(1);
        checkOutput("t2_start_once", ifA.core_start, 0);
        checkOutput("t2_decrypt", ifA.core_decrypt, 0);
        step(15);
        coreDone = 1'b1;
        coreResult = RES1;
        step(1);
        coreDone = 1'b0;
        checkOutput("t2_result", ifA.result, RES1);
        checkOutput("t2_valid", ifA.result_valid, 1);
        checkOutput("t2_state", ifA.state, 4);
        checkOutput("t2_err", ifA.err, 0);

        // Incomplete entries are ignored; a held button captures once.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        applyStimulus(KEY1, 15);
        pressGo();
        checkOutput("t3_key_state", ifA.state, 0);
        checkOutput("t3_key_clr_n", ifA.entry_clr_n, 1);
        checkOutput("t3_key_reg", ifA.key_reg, 0);
        applyStimulus(KEY1, 16);
        pressGo();
        step(2);
        applyStimulus(DATA1, 15);
        pressGo();
        checkOutput("t3_data_state", ifA.state, 1);
        checkOutput("t3_data_clr_n", ifA.entry_clr_n, 1);
        checkOutput("t3_data_reg", ifA.data_reg, 0);
        applyStimulus(DATA1, 16);
        step(1);
        goN = 1'b0;
        startCount = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (i == 0) checkOutput("t3_hold_state", ifA.state, 2);
            if (i == 5) values = ONES;
            startCount += int'(ifA.core_start);
        end
        goN = 1'b1;
        checkOutput("t3_hold_starts", startCount, 1);
        checkOutput("t3_hold_data", ifA.data_reg, DATA1);
        coreDone = 1'b1;
        coreResult = RES1;
        step(1);
        coreDone = 1'b0;
        checkOutput("t3_done_state", ifA.state, 4);

        // Second block under the same key, decrypt direction.
        pressGo();
        checkOutput("t6_state", ifA.state, 1);
        checkOutput("t6_key", ifA.key_reg, KEY1);
        checkOutput("t6_valid", ifA.result_valid, 0);
        coreDone = 1'b1;
        coreResult = RES2;
        step(1);
        coreDone = 1'b0;
        checkOutput("t6_stray_state", ifA.state, 1);
        checkOutput("t6_stray_result", ifA.result, RES1);
        applyStimulus(ONES, 16);
        decryptSw = 1'b1;
        pressGo();
        checkOutput("t6_start", ifA.core_start, 1);
        step(1);
        checkOutput("t6_decrypt", ifA.core_decrypt, 1);
        checkOutput("t6_data", ifA.data_reg, ONES);

        // Short-timeout instance: done on the terminal BUSY cycle wins.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        decryptSw = 1'b0;
        applyStimulus(KEY1, 16);
        pressGo();
        step(2);
        applyStimulus(DATA1, 16);
        pressGo();
        checkOutput("t5_start", ifB.state, 2);
        step(8);
        checkOutput("t5_busy8", ifB.state, 3);
        coreDone = 1'b1;
        coreResult = RES2;
        step(1);
        coreDone = 1'b0;
        checkOutput("t5_state", ifB.state, 4);
        checkOutput("t5_err", ifB.err, 0);
        checkOutput("t5_result", ifB.result, RES2);

        // Timeout, then recovery back to key entry.
        pressGo();
        checkOutput("t4_data_state", ifB.state, 1);
        pressGo();
        checkOutput("t4_start", ifB.state, 2);
        step(8);
        checkOutput("t4_busy8", ifB.state, 3);
        checkOutput("t4_err_early", ifB.err, 0);
        step(1);
        checkOutput("t4_state", ifB.state, 5);
        checkOutput("t4_err", ifB.err, 1);
        checkOutput("t4_result_held", ifB.result, RES2);
        pressGo();
        checkOutput("t4_rec_state", ifB.state, 0);
        checkOutput("t4_rec_err", ifB.err, 0);
        checkOutput("t4_rec_key", ifB.key_reg, 0);
        checkOutput("t4_rec_data", ifB.data_reg, 0);
        checkOutput("t4_rec_result", ifB.result, 0);
        checkOutput("t4_rec_clr_n", ifB.entry_clr_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/des_load_sequencer.md
Name: des_load_sequencer

Overview:
- Sits directly downstream of the 16-digit hex switch-entry stage; consumes its 64-bit `values` bus and `nEntered` count.
- First captures a 64-bit key, then a 64-bit data block. Issues a start/done handshake to the DES cipher core and latches the core's result for display.
- After each capture, re-arms the entry stage so the user can type the next block.
- Supports repeated blocks under the same key, and recovers from a core timeout.

Parameters:
- DIGITS, 16: nEntered value that marks a complete 64-bit entry.
- CLR_CYCLES, 2: number of cycles entry_clr_n is held low after each capture (1..15).
- TIMEOUT, 1024: maximum cycles to wait in BUSY for core_done (2..65535).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- values  in  64  assembled hex entry from the input stage.
- nEntered  in  5  number of digits entered so far.
- go_n  in  1  active-low commit pushbutton, already synchronised to clk.
- decrypt_sw  in  1  0 = encrypt, 1 = decrypt.
- core_done  in  1  cipher core completion strobe.
- core_result  in  64  cipher core output; valid in the cycle core_done is high.
- entry_clr_n  out  1  active-low clear to the entry stage's reset.
- key_reg  out  64  captured key.
- data_reg  out  64  captured data block.
- core_start  out  1  one-cycle start pulse to the core.
- core_decrypt  out  1  direction latched at start.
- result  out  64  latched core output.
- result_valid  out  1  high while result holds a fresh output.
- err  out  1  core timeout flag.
- state  out  3  FSM state encoding, for LEDs/debug.

Behaviour:
- **Reset values** (rst=1 at posedge): state=KEY(0); key_reg, data_reg, result = 0; core_start=0; core_decrypt=0; result_valid=0; err=0; entry_clr_n=1; go edge register=1; counters=0. Reset overrides all other inputs in that cycle, including mid-BUSY; a later core_done is ignored.
- **press**: go_prev==1 && go_n==0, evaluated each cycle. go_prev <= go_n every cycle. Exactly one press per falling edge; holding the button generates nothing further.
- **full**: nEntered == DIGITS.
- **State encodings:** KEY=0, DATA=1, START=2, BUSY=3, DONE=4, ERROR=5.
- **KEY:**
  - press && full: key_reg<=values; start clear pulse; go to DATA.
  - press && !full: ignored, remain in KEY.
- **DATA:**
  - press && full && clear pulse not active: data_reg<=values; start clear pulse; go to START.
  - Press while the clear pulse is active, or with !full: ignored.
- **START:** lasts exactly one cycle. core_start=1 and core_decrypt<=decrypt_sw this cycle; timeout counter<=0; go to BUSY.
- **BUSY:**
  - core_done=1: result<=core_result; result_valid<=1; go to DONE.
  - Else counter increments. When counter == TIMEOUT-1 with no done: err<=1; go to ERROR.
  - core_done in the same cycle as the terminal count: done wins, err stays 0.
  - press is ignored in BUSY.
- **DONE:** press → result_valid<=0; go to DATA (key retained; entry stage was already cleared after data capture). Any core_done while not in BUSY is ignored.
- **ERROR:** press → err<=0; key_reg, data_reg, result <= 0; start clear pulse; go to KEY.
- **Clear pulse:**
  - entry_clr_n is driven 0 for exactly CLR_CYCLES consecutive cycles, starting the cycle after the capture edge, via a 4-bit down-counter.
  - A new pulse request while one is active reloads the counter.
- **core_start timing:** high only in the START cycle, never two consecutive cycles. Latency from the data-capture press to core_start = 1 cycle.
- **Result:** result_valid falls only on the DONE press or reset. result is held until the next core_done or reset.
- **Width rules:** timeout counter is 16 bits; comparisons are unsigned.

Test Plan:
1. **Reset mid-BUSY.** Reset, then apply nEntered=16, values=64'h133457799BBCDFF1, go press → key_reg=133457799BBCDFF1; state=1; entry_clr_n low exactly 2 cycles. Drive nEntered=16 again, assert rst during BUSY → all outputs at reset values; a core_done one cycle after reset is ignored (result=0, result_valid=0).
2. **Full encrypt flow.** Key as in 1, then data 64'h0123456789ABCDEF with decrypt_sw=0 and a press → core_start high exactly one cycle after the press; core_decrypt=0. core_done after 16 cycles with core_result=64'h85E813540F0AB405 → result matches; result_valid=1; state=4.
3. **Incomplete entry.** nEntered=15 with a press in KEY and in DATA → no capture, state unchanged, entry_clr_n stays 1. A press held low for 50 cycles with nEntered=16 → exactly one capture.
4. **Timeout.** TIMEOUT=8, no core_done → err=1 and state=5 exactly 8 cycles after START. Next press → err=0, key/data/result cleared, state=0, clear pulse issued.
5. **Done vs timeout tie.** TIMEOUT=8, core_done asserted on the 8th BUSY cycle → state=4, err=0, result latched.
6. **Second block, same key.** From DONE, press → state=1, key_reg unchanged. Enter 64'hFFFFFFFFFFFFFFFF with decrypt_sw=1 → core_decrypt=1 at START; a stray core_done while in DATA is ignored.
